l2_req_arb: RTL and testbench

//  Two-requester arbiter in front of the L2's single L1-side request/response port.

---
 rtl/l2_arb_pkg.sv | 21 ++
 rtl/l2_arb_pick.sv | 28 ++
 rtl/l2_req_arb.sv | 157 +++++++++++++++
 tb/tb_l2_req_arb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 request arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which L1 side owns the in-flight transaction
//   MEM_LD/ST   : memory opcodes the arbiter needs to decode
package l2_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [3:0] MEM_LD = 4'd4;
  localparam logic [3:0] MEM_ST = 4'd7;

endpackage

// File: rtl/l2_arb_pick.sv
// Two-way requester picker.
// Ports:
//   i_valid_i : I-side request valid
//   i_valid_d : D-side request valid
//   i_prio    : side that wins when both request (fixed D, or rr pointer)
//   o_grant   : some requester is picked this cycle
//   o_owner   : picked requester (OWN_D when nothing requests)
module l2_arb_pick
  import l2_arb_pkg::*;
(
  input  logic   i_valid_i,
  input  logic   i_valid_d,
  input  owner_t i_prio,
  output logic   o_grant,
  output owner_t o_owner
);

  always_comb begin
    o_grant = i_valid_i | i_valid_d;
    o_owner = OWN_D;
    if (i_valid_i && i_valid_d) begin
      o_owner = i_prio;
    end else if (i_valid_i) begin
      o_owner = OWN_I;
    end
  end

endmodule

// File: rtl/l2_req_arb.sv
// Two-requester arbiter sharing the L2's single request/response port between
// the L1 I-cache (loads) and the L1 D-cache (loads and stores). One transaction
// in flight; the owner is recorded and the L2 reply is routed back to it.
//
// Optional feature: define L2_ARB_RR_EN for round-robin arbitration between the
// two sides. Without it, D always beats I on a simultaneous request.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_l1i_req_*, o_l1i_req_ack I-side request channel
//   o_l1i_rsp_valid/_data      I-side load response (1-cycle pulse)
//   i_l1d_req_*, o_l1d_req_ack D-side request channel (with store data)
//   o_l1d_rsp_valid/_data      D-side load response (1-cycle pulse)
//   o_l2_req_*, i_l2_req_ack   request to the L2, held stable until ack
//   i_l2_rsp_valid/_data       load response from the L2
module l2_req_arb
  import l2_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_l1i_req_valid,
  output logic              o_l1i_req_ack,
  input  logic [ADDR_W-1:0] i_l1i_req_addr,
  input  logic [OP_W-1:0]   i_l1i_req_opcode,
  output logic              o_l1i_rsp_valid,
  output logic [DATA_W-1:0] o_l1i_rsp_data,
  input  logic              i_l1d_req_valid,
  output logic              o_l1d_req_ack,
  input  logic [ADDR_W-1:0] i_l1d_req_addr,
  input  logic [DATA_W-1:0] i_l1d_req_store_data,
  input  logic [OP_W-1:0]   i_l1d_req_opcode,
  output logic              o_l1d_rsp_valid,
  output logic [DATA_W-1:0] o_l1d_rsp_data,
  output logic              o_l2_req_valid,
  input  logic              i_l2_req_ack,
  output logic [ADDR_W-1:0] o_l2_req_addr,
  output logic [DATA_W-1:0] o_l2_req_store_data,
  output logic [OP_W-1:0]   o_l2_req_opcode,
  input  logic              i_l2_rsp_valid,
  input  logic [DATA_W-1:0] i_l2_rsp_data
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_req_addr;
  logic [DATA_W-1:0] r_req_sdata;
  logic [OP_W-1:0]   r_req_op;
  logic              r_rsp_pulse;
  logic [DATA_W-1:0] r_rsp_data;

  logic              w_grant;
  logic              w_take;
  logic              w_rsp_take;
  owner_t            w_pick_owner;
  owner_t            w_prio;

  // Prio pointer: names the side that wins the next simultaneous contest.
`ifdef L2_ARB_RR_EN
  owner_t r_rr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr <= OWN_D;
    end else if (w_take) begin
      r_rr <= (w_pick_owner == OWN_D) ? OWN_I : OWN_D;
    end
  end

  assign w_prio = r_rr;
`else
  assign w_prio = OWN_D;
`endif

  l2_arb_pick u_pick (
    .i_valid_i (i_l1i_req_valid),
    .i_valid_d (i_l1d_req_valid),
    .i_prio    (w_prio),
    .o_grant   (w_grant),
    .o_owner   (w_pick_owner)
  );

  // Grants only happen in idle, so a new owner cannot appear before the
  // previous response pulse has been driven.
  assign w_take     = (r_state == ARB_IDLE) && w_grant;
  assign w_rsp_take = (r_state == ARB_RSP) && i_l2_rsp_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (w_grant) w_state_nxt = ARB_REQ;
      ARB_REQ: begin
        if (i_l2_req_ack) begin
          // Only loads get a reply; anything else retires on ack.
          w_state_nxt = (r_req_op == OP_W'(MEM_LD)) ? ARB_RSP : ARB_IDLE;
        end
      end
      ARB_RSP:  if (i_l2_rsp_valid) w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWN_D;
      r_req_addr  <= '0;
      r_req_sdata <= '0;
      r_req_op    <= '0;
      r_rsp_pulse <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_pulse <= w_rsp_take;
      if (w_take) begin
        r_owner <= w_pick_owner;
        if (w_pick_owner == OWN_D) begin
          r_req_addr  <= i_l1d_req_addr;
          r_req_sdata <= i_l1d_req_store_data;
          r_req_op    <= i_l1d_req_opcode;
        end else begin
          r_req_addr  <= i_l1i_req_addr;
          r_req_sdata <= '0;
          r_req_op    <= i_l1i_req_opcode;
        end
      end
      if (w_rsp_take) begin
        r_rsp_data <= i_l2_rsp_data;
      end
    end
  end

  assign o_l2_req_valid      = (r_state == ARB_REQ);
  assign o_l2_req_addr       = r_req_addr;
  assign o_l2_req_store_data = r_req_sdata;
  assign o_l2_req_opcode     = r_req_op;

  // Ack is a straight pass-through of the L2 accept, steered to the owner.
  assign o_l1i_req_ack = o_l2_req_valid && (r_owner == OWN_I) && i_l2_req_ack;
  assign o_l1d_req_ack = o_l2_req_valid && (r_owner == OWN_D) && i_l2_req_ack;

  assign o_l1i_rsp_valid = r_rsp_pulse && (r_owner == OWN_I);
  assign o_l1d_rsp_valid = r_rsp_pulse && (r_owner == OWN_D);
  assign o_l1i_rsp_data  = r_rsp_data;
  assign o_l1d_rsp_data  = r_rsp_data;

  // L2 protocol checks: replies and accepts are only legal in their own state.
  a_rsp_in_rsp : assert property (@(posedge clk) disable iff (reset)
    i_l2_rsp_valid |-> (r_state == ARB_RSP));
  a_ack_in_req : assert property (@(posedge clk) disable iff (reset)
    i_l2_req_ack |-> (r_state == ARB_REQ));

endmodule

// File: tb/tb_l2_req_arb.sv
module tb_l2_req_arb;
  import l2_arb_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned OP_W   = 4;

  logic              clk;
  logic              reset;
  logic              iv, dv, l2_ack, l2_rv;
  logic [ADDR_W-1:0] ia, da;
  logic [OP_W-1:0]   iop, dop;
  logic [DATA_W-1:0] dsd, l2_rd;
  logic              i_ack, d_ack, i_rv, d_rv, l2_v;
  logic [DATA_W-1:0] i_rd, d_rd, l2_sd;
  logic [ADDR_W-1:0] l2_a;
  logic [OP_W-1:0]   l2_op;

  int n_vec = 0;
  int n_err = 0;

  l2_req_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .i_l1i_req_valid      (iv),
    .o_l1i_req_ack        (i_ack),
    .i_l1i_req_addr       (ia),
    .i_l1i_req_opcode     (iop),
    .o_l1i_rsp_valid      (i_rv),
    .o_l1i_rsp_data       (i_rd),
    .i_l1d_req_valid      (dv),
    .o_l1d_req_ack        (d_ack),
    .i_l1d_req_addr       (da),
    .i_l1d_req_store_data (dsd),
    .i_l1d_req_opcode     (dop),
    .o_l1d_rsp_valid      (d_rv),
    .o_l1d_rsp_data       (d_rd),
    .o_l2_req_valid       (l2_v),
    .i_l2_req_ack         (l2_ack),
    .o_l2_req_addr        (l2_a),
    .o_l2_req_store_data  (l2_sd),
    .o_l2_req_opcode      (l2_op),
    .i_l2_rsp_valid       (l2_rv),
    .i_l2_rsp_data        (l2_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running required done");
    $fatal(1);
  end

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; iv = 0; dv = 0; l2_ack = 0; l2_rv = 0;
    ia = '0; da = '0; iop = '0; dop = '0; dsd = '0; l2_rd = '0;
    step(); step();
    n_vec++; if (l2_v !== 1'b0) begin n_err++; $display("FAIL rst_l2_valid got %b want 0", l2_v); end
    n_vec++; if (l2_a !== '0) begin n_err++; $display("FAIL rst_l2_addr got %h want 0", l2_a); end
    n_vec++; if (l2_sd !== '0 || l2_op !== '0) begin n_err++; $display("FAIL rst_l2_fields got %h/%h want 0", l2_sd, l2_op); end
    n_vec++; if ({i_ack, d_ack, i_rv, d_rv} !== 4'b0) begin n_err++; $display("FAIL rst_l1_flags got %b want 0000", {i_ack, d_ack, i_rv, d_rv}); end
    n_vec++; if (i_rd !== '0 || d_rd !== '0) begin n_err++; $display("FAIL rst_rsp_data got %h/%h want 0", i_rd, d_rd); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_i_load();
    iv = 1; ia = 32'h1000; iop = MEM_LD;
    step();
    n_vec++; if (l2_v !== 1'b1 || l2_a !== 32'h1000 || l2_op !== 4'd4) begin n_err++; $display("FAIL iload_issue got v=%b a=%h op=%h want 1/1000/4", l2_v, l2_a, l2_op); end
    n_vec++; if (l2_sd !== '0) begin n_err++; $display("FAIL iload_sdata got %h want 0", l2_sd); end
    step();
    l2_ack = 1; #1;
    n_vec++; if (i_ack !== 1'b1 || d_ack !== 1'b0) begin n_err++; $display("FAIL iload_ack got i=%b d=%b want 1/0", i_ack, d_ack); end
    step();
    l2_ack = 0; iv = 0;
    n_vec++; if (l2_v !== 1'b0) begin n_err++; $display("FAIL iload_drop got %b want 0", l2_v); end
    l2_rv = 1; l2_rd = {16{8'hAA}};
    step();
    l2_rv = 0;
    n_vec++; if (i_rv !== 1'b1 || i_rd !== {16{8'hAA}}) begin n_err++; $display("FAIL iload_rsp got v=%b d=%h want 1/aa..", i_rv, i_rd); end
    n_vec++; if (d_rv !== 1'b0) begin n_err++; $display("FAIL iload_d_quiet got %b want 0", d_rv); end
    step();
    n_vec++; if (i_rv !== 1'b0) begin n_err++; $display("FAIL iload_pulse got %b want 0", i_rv); end
  endtask

  task automatic test_d_store();
    dv = 1; da = 32'h2040; dop = MEM_ST; dsd = {16{8'h55}};
    step();
    n_vec++; if (l2_v !== 1'b1 || l2_a !== 32'h2040 || l2_op !== 4'd7 || l2_sd !== {16{8'h55}}) begin
      n_err++; $display("FAIL dst_issue got v=%b a=%h op=%h sd=%h", l2_v, l2_a, l2_op, l2_sd); end
    step();
    l2_ack = 1; #1;
    n_vec++; if (d_ack !== 1'b1 || i_ack !== 1'b0 || l2_sd !== {16{8'h55}}) begin n_err++; $display("FAIL dst_ack got d=%b i=%b sd=%h", d_ack, i_ack, l2_sd); end
    step();
    l2_ack = 0; dv = 0;
    n_vec++; if (l2_v !== 1'b0) begin n_err++; $display("FAIL dst_drop got %b want 0", l2_v); end
    step();
    n_vec++; if (i_rv !== 1'b0 || d_rv !== 1'b0) begin n_err++; $display("FAIL dst_no_rsp got i=%b d=%b want 0/0", i_rv, d_rv); end
    // Back in idle: a fresh I request must be issued one cycle later.
    iv = 1; ia = 32'h1234; iop = MEM_ST;
    step();
    iv = 0;
    n_vec++; if (l2_v !== 1'b1 || l2_a !== 32'h1234) begin n_err++; $display("FAIL dst_idle_again got v=%b a=%h want 1/1234", l2_v, l2_a); end
    step();
    l2_ack = 1; step(); l2_ack = 0; step();
  endtask

  task automatic test_contest_fixed();
    iv = 1; ia = 32'h3000; iop = MEM_LD;
    dv = 1; da = 32'h4000; dop = MEM_LD; dsd = '0;
    step();
    n_vec++; if (l2_a !== 32'h4000 || l2_v !== 1'b1) begin n_err++; $display("FAIL both_first got a=%h v=%b want 4000/1", l2_a, l2_v); end
    step();
    l2_ack = 1; #1;
    n_vec++; if (d_ack !== 1'b1 || i_ack !== 1'b0) begin n_err++; $display("FAIL both_ack_d got d=%b i=%b want 1/0", d_ack, i_ack); end
    step();
    l2_ack = 0; dv = 0;
    n_vec++; if (l2_v !== 1'b0) begin n_err++; $display("FAIL both_i_waits got %b want 0", l2_v); end
    l2_rv = 1; l2_rd = {16{8'h11}};
    step();
    l2_rv = 0;
    n_vec++; if (d_rv !== 1'b1 || l2_v !== 1'b0 || d_rd !== {16{8'h11}}) begin n_err++; $display("FAIL both_d_rsp got rv=%b v=%b d=%h", d_rv, l2_v, d_rd); end
    step();
    n_vec++; if (l2_v !== 1'b1 || l2_a !== 32'h3000 || d_rv !== 1'b0) begin n_err++; $display("FAIL both_i_issue got v=%b a=%h drv=%b", l2_v, l2_a, d_rv); end
    step();
    l2_ack = 1; #1;
    n_vec++; if (i_ack !== 1'b1) begin n_err++; $display("FAIL both_ack_i got %b want 1", i_ack); end
    step();
    l2_ack = 0; iv = 0; l2_rv = 1; l2_rd = {16{8'h22}};
    step();
    l2_rv = 0;
    n_vec++; if (i_rv !== 1'b1 || d_rv !== 1'b0 || i_rd !== {16{8'h22}}) begin n_err++; $display("FAIL both_i_rsp got i=%b d=%b data=%h", i_rv, d_rv, i_rd); end
    step();
  endtask

  task automatic test_back_to_back();
    int  i_grants;
    logic exp_d;
    i_grants = 0;
    iv = 1; ia = 32'h5000; iop = MEM_LD;
    dv = 1; da = 32'h6000; dop = MEM_LD;
    for (int k = 0; k < 4; k++) begin
      step();
`ifdef L2_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      if (l2_a == 32'h5000) i_grants++;
      n_vec++; if (l2_v !== 1'b1 || l2_a !== (exp_d ? 32'h6000 : 32'h5000)) begin
        n_err++; $display("FAIL b2b_grant%0d got v=%b a=%h want d=%b", k, l2_v, l2_a, exp_d); end
      step();
      l2_ack = 1;
      step();
      l2_ack = 0; l2_rv = 1; l2_rd = DATA_W'(k);
      step();
      l2_rv = 0;
      n_vec++; if ((exp_d ? d_rv : i_rv) !== 1'b1) begin n_err++; $display("FAIL b2b_rsp%0d got i=%b d=%b want d=%b", k, i_rv, d_rv, exp_d); end
      if (k == 3) begin iv = 0; dv = 0; end
    end
    step();
`ifdef L2_ARB_RR_EN
    n_vec++; if (i_grants !== 2) begin n_err++; $display("FAIL b2b_i_grants got %0d want 2", i_grants); end
`else
    n_vec++; if (i_grants !== 0) begin n_err++; $display("FAIL b2b_i_grants got %0d want 0", i_grants); end
`endif
  endtask

  task automatic test_reset_in_rsp();
    iv = 1; ia = 32'h8000; iop = MEM_LD;
    step();
    step();
    l2_ack = 1;
    step();
    l2_ack = 0; iv = 0; reset = 1;
    step();
    n_vec++; if ({l2_v, i_ack, d_ack, i_rv, d_rv} !== 5'b0 || l2_a !== '0 || l2_op !== '0) begin
      n_err++; $display("FAIL rrsp_outputs got v=%b a=%h op=%h flags=%b", l2_v, l2_a, l2_op, {i_ack, d_ack, i_rv, d_rv}); end
    n_vec++; if (i_rd !== '0 || l2_sd !== '0) begin n_err++; $display("FAIL rrsp_data got %h/%h want 0", i_rd, l2_sd); end
    // Late L2 reply while still in reset must be dropped.
    l2_rv = 1; l2_rd = {16{8'hFF}};
    step();
    l2_rv = 0; reset = 0;
    n_vec++; if (i_rv !== 1'b0 || d_rv !== 1'b0) begin n_err++; $display("FAIL rrsp_late got i=%b d=%b want 0/0", i_rv, d_rv); end
    step();
    n_vec++; if (i_rv !== 1'b0 || d_rv !== 1'b0 || l2_v !== 1'b0) begin n_err++; $display("FAIL rrsp_quiet got i=%b d=%b v=%b", i_rv, d_rv, l2_v); end
  endtask

  task automatic test_ack_delay();
    dv = 1; da = 32'h7000; dop = MEM_LD; dsd = {16{8'h3C}};
    step();
    for (int k = 0; k < 5; k++) begin
      n_vec++; if (l2_v !== 1'b1 || l2_a !== 32'h7000 || l2_op !== 4'd4 || l2_sd !== {16{8'h3C}} || d_ack !== 1'b0) begin
        n_err++; $display("FAIL dly_hold%0d got v=%b a=%h op=%h ack=%b", k, l2_v, l2_a, l2_op, d_ack); end
      step();
    end
    l2_ack = 1; #1;
    n_vec++; if (d_ack !== 1'b1) begin n_err++; $display("FAIL dly_ack got %b want 1", d_ack); end
    step();
    l2_ack = 0; dv = 0; #1;
    n_vec++; if (d_ack !== 1'b0 || l2_v !== 1'b0) begin n_err++; $display("FAIL dly_ack_pulse got ack=%b v=%b want 0/0", d_ack, l2_v); end
    l2_rv = 1; l2_rd = {16{8'h99}};
    step();
    l2_rv = 0;
    n_vec++; if (d_rv !== 1'b1 || d_rd !== {16{8'h99}}) begin n_err++; $display("FAIL dly_rsp got v=%b d=%h", d_rv, d_rd); end
    step();
  endtask

  initial begin
    test_reset();
    test_i_load();
    test_d_store();
    test_contest_fixed();
    test_back_to_back();
    test_reset_in_rsp();
    test_ack_delay();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
